uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
// - Serial transmitter behind the message buffer: takes one byte per send/txdone handshake and drives an 8N1 (or 8N2) UART line.
// - The buffer's cell-to-UART path emits each message as three bytes (i, j, status); this block serialises each byte and reports txdone when it is finished.
// - Sits between the buffer's txdata/send/txdone ports and the FPGA TX pin.
// PARAMETERS
// - CLKS_PER_BIT  434  clk cycles per UART bit (50 MHz / 115200); legal range >= 2
// - STOP_BITS     1    number of stop bits; legal values 1 or 2
// - GAP_CYCLES    2    idle cycles after txdone during which send is ignored; legal range >= 2
// PORTS
// - clk      in   1  system clock, rising edge
// - rst      in   1  synchronous, active-high reset
// - txdata   in   8  byte to transmit; sampled only on acceptance
// - send     in   1  level request; a byte is accepted when send=1 in IDLE
// - txdone   out  1  one-cycle pulse: byte fully shifted out, stop bit(s) included
// - busy     out  1  high from the acceptance cycle through the end of GAP
// - tx       out  1  serial line, idle high
// BEHAVIOUR
// - Reset (rst=1 at a clock edge, in any state): tx=1, txdone=0, busy=0, state=IDLE; bit counter and baud counter are cleared.
//   - Reset mid-frame aborts the frame immediately. No txdone is issued for the aborted byte.
// - Data path: the shift register is loaded with txdata on acceptance. Later changes to txdata have no effect on that frame.
// - FSM: IDLE -> START -> DATA -> STOP -> GAP -> IDLE.
//   - IDLE: tx=1. On send=1, latch txdata, set busy=1, go to START on the next cycle.
//   - START: tx=0 for CLKS_PER_BIT cycles.
//   - DATA: 8 bits, LSB first, each held on tx for CLKS_PER_BIT cycles. A 3-bit index selects the bit; it wraps 7->0 on exit.
//   - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
//     - txdone=1 for exactly one cycle, in the last STOP cycle.
//   - GAP: tx=1, busy=1, send ignored, for GAP_CYCLES cycles, then IDLE.
//     - GAP exists because the buffer holds send high and updates txdata one cycle after it sees txdone. GAP prevents a stale byte from being re-sent.
// - Timing:
//   - tx falls on the cycle after acceptance.
//   - Frame length = (9 + STOP_BITS)*CLKS_PER_BIT cycles. At the defaults with 1 stop bit that is 4340 cycles.
//   - Earliest next acceptance = GAP_CYCLES cycles after txdone.
// - Baud counter:
//   - Width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1.
//   - The state or bit advances when the counter reaches CLKS_PER_BIT-1. The counter reloads to 0 on every advance.
// - Boundary conditions:
//   - send=1 while busy: ignored, no queuing. The buffer must hold send until txdone.
//   - send held high continuously: back-to-back frames separated by exactly GAP_CYCLES idle cycles.
//   - rst and send asserted together: rst wins and the byte is not accepted.
// - tx is driven from a flop. There is no combinational path from any input to tx or txdone.
// STRUCTURE
// - Shared package uart_pkg:
//   - state enum (IDLE, START, DATA, STOP, GAP);
//   - default CLKS_PER_BIT for the board clock;
//   - frame-length helper constant.
// - One natural sub-module: uart_baud_tick. It is a CLKS_PER_BIT counter with sync clear, producing a one-cycle tick. uart_rx reuses it with a half-bit preload.
// - Everything else (FSM, shift register, bit index) is flat in uart_tx.
// TESTING (CLKS_PER_BIT=4, STOP_BITS=1, GAP_CYCLES=2 unless noted)
// 1. Single byte: send=1 with txdata=8'hA5 for 1 cycle.
//    -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles;
//    -> txdone pulses once in cycle 40 after acceptance; busy drops 2 cycles later.
// 2. Buffer emulation: send held high; txdata changed to 8'h3C one cycle after txdone.
//    -> the second frame carries 8'h3C, never a repeat of 8'hA5;
//    -> the gap between frames is exactly 2 idle cycles.
// 3. Data change mid-frame: txdata changes 8'h00 -> 8'hFF during DATA.
//    -> the line still carries all-zero data bits.
// 4. Reset mid-frame: rst=1 during the 4th data bit.
//    -> next cycle tx=1, busy=0, no txdone;
//    -> a following send transmits a clean frame.
// 5. Two stop bits: STOP_BITS=2, byte 8'h81.
//    -> stop level lasts 8 cycles; txdone arrives at cycle 44.
// 6. Three-byte message {i=8'h30, j=8'h50, status=8'h05} driven through the buffer handshake.
//    -> a line decoder recovers 30, 50, 05 in order;
//    -> exactly 3 txdone pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: FSM state encoding, board defaults
// and the frame-length helper.
package uart_pkg;

    localparam int BYTE_W               = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP
    } uart_state_t;

    // Cycles from the first start-bit cycle through the last stop-bit cycle.
    function automatic int frame_cycles(input int clks_per_bit, input int stop_bits);
        return (1 + BYTE_W + stop_bits) * clks_per_bit;
    endfunction

    localparam int DEFAULT_FRAME_CYCLES = frame_cycles(DEFAULT_CLKS_PER_BIT, 1);

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the message buffer (master) and the UART transmitter
// (slave): the buffer holds send with txdata until it sees txdone.
interface uart_tx_if
    import uart_pkg::*;
;
    logic [BYTE_W-1:0] txdata;
    logic              send;
    logic              txdone;
    logic              busy;

    modport master (
        output txdata,
        output send,
        input  txdone,
        input  busy
    );

    modport slave (
        input  txdata,
        input  send,
        output txdone,
        output busy
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and ticks on the last count.
// clr holds the counter at PRELOAD (the receiver uses a half-bit preload).
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PRELOAD      = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick,
    output logic pre_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_NEAR = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PRELOAD);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= CNT_LOAD;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // pre_tick lets a client register an output that must coincide with tick.
    assign tick     = !clr && (cnt == CNT_LAST);
    assign pre_tick = !clr && (cnt == CNT_NEAR);

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter: accepts one byte per send/txdone handshake and
// shifts it out LSB first; tx, txdone and busy all come straight from flops.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1,
    parameter int GAP_CYCLES   = 2
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_if.slave      bus,
    output logic          tx
);

    // GAP state covers GAP_CYCLES-1 cycles; the IDLE cycle that follows is the
    // last idle cycle before the next start bit, so the line gap is GAP_CYCLES.
    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES - 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 2);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    uart_state_t       state;
    uart_state_t       state_next;
    logic [BYTE_W-1:0] data_q;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_next;
    logic [GAP_W-1:0]  gap_cnt;
    logic              accept;
    logic              tick;
    logic              pre_tick;
    logic              baud_clr;
    logic              tx_next;
    logic              txdone_next;
    logic              busy_next;
    logic              txdone_q;
    logic              busy_q;

    assign baud_clr = (state == IDLE) || (state == GAP);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .PRELOAD      (0)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clr      (baud_clr),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_comb begin
        state_next   = state;
        bit_idx_next = bit_idx;
        accept       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.send) begin
                    accept     = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (tick) state_next = DATA;
            end
            DATA: begin
                if (tick) begin
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_idx == STOP_LAST) begin
                        bit_idx_next = 3'd0;
                        state_next   = GAP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_next = IDLE;
            end
            default: begin
                state_next   = IDLE;
                bit_idx_next = 3'd0;
            end
        endcase
    end

    // Output flops are loaded with the values belonging to the next state.
    always_comb begin
        tx_next     = 1'b1;
        txdone_next = (state == STOP) && pre_tick && (bit_idx == STOP_LAST);
        busy_next   = (state_next != IDLE);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = data_q[bit_idx_next];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_idx  <= 3'd0;
            gap_cnt  <= '0;
            tx       <= 1'b1;
            txdone_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_next;
            bit_idx  <= bit_idx_next;
            gap_cnt  <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            tx       <= tx_next;
            txdone_q <= txdone_next;
            busy_q   <= busy_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) data_q <= bus.txdata;
    end

    assign bus.txdone = txdone_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a 1-stop and a 2-stop instance checked cycle by cycle
// against a bit-period waveform model, plus a mid-bit sampling line decoder.
module tb_uart_tx;

    localparam int CPB = 4;
    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] txdata = 8'h00;
    logic       tx_a, tx_b;
    logic       tx_m, txdone_m, busy_m;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] dec_q[$];

    always #5 clk = ~clk;

    uart_tx_if ifa ();
    uart_tx_if ifb ();

    assign ifa.txdata = txdata;
    assign ifb.txdata = txdata;
    assign ifa.send   = send & ~sel;
    assign ifb.send   = send & sel;

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .GAP_CYCLES(GAP)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa.slave), .tx (tx_a));

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .GAP_CYCLES(GAP)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb.slave), .tx (tx_b));

    assign tx_m     = sel ? tx_b : tx_a;
    assign txdone_m = sel ? ifb.txdone : ifa.txdone;
    assign busy_m   = sel ? ifb.busy : ifa.busy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line level k cycles after acceptance: start, 8 data bits LSB first, then stop.
    function automatic logic exp_tx(input logic [7:0] d, input int k);
        int b;
        b = (k - 1) / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b - 1];
        return 1'b1;
    endfunction

    task automatic start_byte(input logic [7:0] d);
        @(negedge clk);
        txdata = d;
        send   = 1'b1;
    endtask

    // Called right after the acceptance cycle's negedge; checks every frame cycle.
    task automatic frame_check(input int stop_bits, input logic [7:0] d, input bit hold,
                               input int chg_at, input logic [7:0] chg_val);
        int f;
        f = (9 + stop_bits) * CPB;
        for (int k = 1; k <= f; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) send = 1'b0;
            if (k == chg_at) txdata = chg_val;
            check_eq($sformatf("tx d=%0h k=%0d", d, k), 32'(tx_m), 32'(exp_tx(d, k)));
            check_eq($sformatf("txdone k=%0d", k), 32'(txdone_m), 32'(k == f));
            check_eq($sformatf("busy k=%0d", k), 32'(busy_m), 32'd1);
        end
    endtask

    // Two cycles after txdone; 'more' emulates the buffer presenting the next byte.
    task automatic gap_check(input bit more, input logic [7:0] next);
        @(negedge clk);
        check_eq("gap1 tx", 32'(tx_m), 32'd1);
        check_eq("gap1 busy", 32'(busy_m), 32'd1);
        check_eq("gap1 txdone", 32'(txdone_m), 32'd0);
        @(negedge clk);
        if (more) txdata = next;
        else      send = 1'b0;
        check_eq("gap2 tx", 32'(tx_m), 32'd1);
        check_eq("gap2 busy", 32'(busy_m), 32'd0);
        if (!more) begin
            @(negedge clk);
            check_eq("idle tx", 32'(tx_m), 32'd1);
            check_eq("idle busy", 32'(busy_m), 32'd0);
        end
    endtask

    initial begin : decoder
        logic [7:0] b;
        b = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_a === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx_a;
                end
                repeat (CPB) @(negedge clk);
                dec_q.push_back(b);
            end
        end
    end

    initial begin : stim
        logic [7:0] d, nb;
        logic [7:0] msg [3];
        int bad, pulses, idx;
        bit pending, done;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst tx_a", 32'(tx_a), 32'd1);
        check_eq("rst busy_a", 32'(ifa.busy), 32'd0);
        check_eq("rst txdone_a", 32'(ifa.txdone), 32'd0);
        check_eq("rst tx_b", 32'(tx_b), 32'd1);
        check_eq("rst busy_b", 32'(ifb.busy), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte, one-cycle send
        start_byte(8'hA5);
        frame_check(1, 8'hA5, 1'b0, 0, 8'h00);
        gap_check(1'b0, 8'h00);

        // Random single bytes
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            start_byte(d);
            frame_check(1, d, 1'b0, 0, 8'h00);
            gap_check(1'b0, 8'h00);
        end

        // Buffer emulation: send held, next byte presented after txdone
        start_byte(8'hA5);
        frame_check(1, 8'hA5, 1'b1, 0, 8'h00);
        gap_check(1'b1, 8'h3C);
        frame_check(1, 8'h3C, 1'b1, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            nb = 8'($urandom);
            gap_check(1'b1, nb);
            frame_check(1, nb, 1'b1, 0, 8'h00);
        end
        gap_check(1'b0, 8'h00);

        // txdata changes after acceptance
        start_byte(8'h00);
        frame_check(1, 8'h00, 1'b0, 10, 8'hFF);
        gap_check(1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            start_byte(d);
            frame_check(1, d, 1'b0, $urandom_range(2, 36), ~d);
            gap_check(1'b0, 8'h00);
        end

        // Reset during the 4th data bit (cycles 17..20 after acceptance)
        d = 8'h5A;
        start_byte(d);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 1) send = 1'b0;
            check_eq($sformatf("pre-abort tx k=%0d", k), 32'(tx_a), 32'(exp_tx(d, k)));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort tx", 32'(tx_a), 32'd1);
        check_eq("abort busy", 32'(ifa.busy), 32'd0);
        check_eq("abort txdone", 32'(ifa.txdone), 32'd0);
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || ifa.txdone !== 1'b0 || ifa.busy !== 1'b0) bad++;
        end
        check_eq("abort quiet cycles", 32'(bad), 32'd0);
        d = 8'($urandom);
        start_byte(d);
        frame_check(1, d, 1'b0, 0, 8'h00);
        gap_check(1'b0, 8'h00);

        // rst and send together: not accepted
        @(negedge clk);
        rst = 1'b1; send = 1'b1; txdata = 8'($urandom);
        @(negedge clk);
        rst = 1'b0; send = 1'b0;
        check_eq("rst+send tx", 32'(tx_a), 32'd1);
        check_eq("rst+send busy", 32'(ifa.busy), 32'd0);
        @(negedge clk);
        check_eq("rst+send tx later", 32'(tx_a), 32'd1);
        check_eq("rst+send busy later", 32'(ifa.busy), 32'd0);

        // Two stop bits
        sel = 1'b1;
        start_byte(8'h81);
        frame_check(2, 8'h81, 1'b0, 0, 8'h00);
        gap_check(1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom);
            start_byte(d);
            frame_check(2, d, 1'b1, 0, 8'h00);
            gap_check(1'b0, 8'h00);
        end
        sel = 1'b0;

        // Three-byte message through the buffer handshake
        repeat (10) @(negedge clk);
        dec_q.delete();
        msg[0] = 8'h30; msg[1] = 8'h50; msg[2] = 8'h05;
        pulses = 0; idx = 0; pending = 1'b0; done = 1'b0;
        @(negedge clk);
        txdata = msg[0];
        send   = 1'b1;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (pending) begin
                pending = 1'b0;
                idx++;
                if (idx < 3) txdata = msg[idx];
                else begin
                    send = 1'b0;
                    done = 1'b1;
                end
            end
            if (ifa.txdone === 1'b1) begin
                pulses++;
                pending = 1'b1;
            end
        end
        send = 1'b0;
        check_eq("msg handshake done", 32'(done), 32'd1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ifa.txdone === 1'b1) pulses++;
        end
        check_eq("msg txdone pulses", 32'(pulses), 32'd3);
        check_eq("msg decoded count", 32'(dec_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("msg byte %0d", i),
                     (i < dec_q.size()) ? 32'(dec_q[i]) : 32'hDEAD, 32'(msg[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
